// File: rtl/mux8bit_rr_arbiter.sv
// Round-robin arbiter and sequencer that shares one registered output word between two requesters.
// Latency: request seen in IDLE -> grant next cycle -> word valid on out the cycle after; bursts stream one word per cycle.
// Backpressure: while out_valid && !out_ready no grant is issued; state, beat count and out are frozen until acceptance.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req1/in1, req2/in2  requesters; each word is held stable until its grant
//   gnt1, gnt2          combinational; the word on inN is consumed this cycle
//   select              mux select, 0 = in1, 1 = in2 (decoded from the registered state)
//   out, out_valid      registered output word and its valid flag
//   out_ready           downstream accepts out this cycle
//   cnt1, cnt2          saturating 16-bit grant counters, present only when ARB_STATS_EN is defined
//
// Optional feature macro: ARB_STATS_EN (adds the cnt1/cnt2 statistics outputs).

module mux8bit_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             select,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    // The beat counter only ever holds 0 .. MAX_BURST-1: the beat that would
    // reach MAX_BURST wraps it straight back to zero.
    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT1 = 2'd1,
        ST_GNT2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_last2;      // 1: requester 2 was served most recently
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last2_nxt;
    logic               w_load;
    logic               w_gnt1;
    logic               w_gnt2;
    logic               w_gnt_any;
    logic               w_select;
    logic               w_burst_end;
    logic [WIDTH-1:0]   w_word;

    // The output register can take a new word when it is empty or being
    // drained this very cycle.
    assign w_load      = !r_out_valid || out_ready;
    assign w_burst_end = (r_beat_cnt == LAST_BEAT);
    assign w_select    = (r_state == ST_GNT2);
    assign w_word      = w_select ? in2 : in1;
    assign w_gnt_any   = w_gnt1 || w_gnt2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_last2_nxt = r_last2;
        w_gnt1      = 1'b0;
        w_gnt2      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // No grants here; only pick the next owner. On contention
                // the requester not served last wins.
                w_cnt_nxt = '0;
                if (req1 && req2) begin
                    w_state_nxt = r_last2 ? ST_GNT1 : ST_GNT2;
                end else if (req1) begin
                    w_state_nxt = ST_GNT1;
                end else if (req2) begin
                    w_state_nxt = ST_GNT2;
                end
            end

            ST_GNT1: begin
                w_gnt1 = req1 && w_load;
                if (!req1) begin
                    // Owner went away: hand over directly, no idle bubble.
                    w_state_nxt = req2 ? ST_GNT2 : ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_gnt1) begin
                    w_last2_nxt = 1'b0;
                    if (w_burst_end) begin
                        // Burst quota used up; yield only if someone waits,
                        // otherwise start a fresh burst in place.
                        w_cnt_nxt = '0;
                        if (req2) begin
                            w_state_nxt = ST_GNT2;
                        end
                    end else begin
                        w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end

            ST_GNT2: begin
                w_gnt2 = req2 && w_load;
                if (!req2) begin
                    w_state_nxt = req1 ? ST_GNT1 : ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_gnt2) begin
                    w_last2_nxt = 1'b1;
                    if (w_burst_end) begin
                        w_cnt_nxt = '0;
                        if (req1) begin
                            w_state_nxt = ST_GNT1;
                        end
                    end else begin
                        w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_last2    <= 1'b1;   // so requester 1 is served first after reset
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_last2    <= w_last2_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output register: capture on grant, drop valid when drained idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_gnt_any) begin
            r_out       <= w_word;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign gnt1      = w_gnt1;
    assign gnt2      = w_gnt2;
    assign select    = w_select;
    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef ARB_STATS_EN
    // ------------------------------------------------------------------
    // Grant statistics, saturating
    // ------------------------------------------------------------------
    logic [15:0] r_cnt1;
    logic [15:0] r_cnt2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_gnt1 && (r_cnt1 != 16'hFFFF)) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
            if (w_gnt2 && (r_cnt2 != 16'hFFFF)) begin
                r_cnt2 <= r_cnt2 + 16'd1;
            end
        end
    end

    assign cnt1 = r_cnt1;
    assign cnt2 = r_cnt2;
`endif

endmodule

// File: tb/tb_mux8bit_rr_arbiter.sv
// Self-checking bench for mux8bit_rr_arbiter: directed scenarios plus a randomized run,
// all compared cycle by cycle against a behavioural model built from the arbitration rules.

module tb_mux8bit_rr_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req1, req2, out_ready;
    logic [7:0] in1, in2;
    logic       gnt1, gnt2, select, out_valid;
    logic [7:0] out;
`ifdef ARB_STATS_EN
    logic [15:0] cnt1, cnt2;
`endif

    int checks   = 0;
    int failures = 0;

    mux8bit_rr_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req1      (req1),
        .in1       (in1),
        .req2      (req2),
        .in2       (in2),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .select    (select),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_STATS_EN
        ,
        .cnt1      (cnt1),
        .cnt2      (cnt2)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: who owns the bus, how many beats it has had in the
    // current tenure, who was served last, and what the output holds.
    // ------------------------------------------------------------------
    int         m_owner;   // 0 = nobody, 1 or 2 = requester
    int         m_last;
    int         m_served;
    bit         m_vld;
    logic [7:0] m_dat;

    task automatic model_reset();
        m_owner  = 0;
        m_last   = 2;
        m_served = 0;
        m_vld    = 0;
        m_dat    = 8'h00;
    endtask

    // Expected {gnt1, gnt2, select, out_valid, out} for the current inputs.
    function automatic logic [11:0] model_exp();
        bit room = !m_vld || out_ready;
        bit g1   = (m_owner == 1) && req1 && room;
        bit g2   = (m_owner == 2) && req2 && room;
        return {g1, g2, (m_owner == 2), m_vld, m_dat};
    endfunction

    task automatic model_clock();
        logic [11:0] e = model_exp();
        bit g1 = e[11];
        bit g2 = e[10];
        bit own_req, oth_req;
        int oth;
        if (g1 || g2) begin
            m_dat = g1 ? in1 : in2;
            m_vld = 1;
            m_last = g1 ? 1 : 2;
            m_served++;
        end else if (out_ready) begin
            m_vld = 0;
        end
        if (m_owner == 0) begin
            if (req1 && req2) m_owner = 3 - m_last;
            else if (req1)    m_owner = 1;
            else if (req2)    m_owner = 2;
            m_served = 0;
        end else begin
            oth     = 3 - m_owner;
            own_req = (m_owner == 1) ? req1 : req2;
            oth_req = (oth == 1) ? req1 : req2;
            if (!own_req) begin
                m_owner  = oth_req ? oth : 0;
                m_served = 0;
            end else if ((g1 || g2) && m_served == MB) begin
                m_served = 0;
                if (oth_req) m_owner = oth;
            end
        end
    endtask

    // Advance one clock: model follows the rising edge, then return at the
    // falling edge where the next inputs are driven.
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; req1 = 0; req2 = 0; out_ready = 1;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1; req1 = 1; req2 = 1; in1 = 8'h5A; in2 = 8'hA5; out_ready = 1;
        #2 rst_n = 0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, 12'h000);
            end
        end
        req1 = 0; req2 = 0;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req1 = (c < 2); req2 = 0; in1 = 8'hAA; out_ready = 1;
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL single c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (c == 1) begin
                checks++;
                if (gnt1 !== 1'b1) begin
                    failures++;
                    $display("FAIL single_gnt_latency got=%b exp=1", gnt1);
                end
            end
            if (c == 2) begin
                checks++;
                if ({out_valid, out} !== 9'h1AA) begin
                    failures++;
                    $display("FAIL single_out got=%h exp=1aa", {out_valid, out});
                end
            end
            if (c == 3) begin
                checks++;
                if ({out_valid, select} !== 2'b00) begin
                    failures++;
                    $display("FAIL single_drain got=%b exp=00", {out_valid, select});
                end
            end
            step();
        end
    endtask

    task automatic test_fairness();
        int k = 0;
        logic [7:0] exp_w;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            req1 = 1; req2 = 1; in1 = 8'h11; in2 = 8'h22; out_ready = 1;
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL fairness c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (m_vld) begin
                exp_w = (((k / MB) % 2) == 0) ? 8'h11 : 8'h22;
                checks++;
                if ({out_valid, out} !== {1'b1, exp_w}) begin
                    failures++;
                    $display("FAIL fairness_seq beat=%0d got=%h exp=%h", k, {out_valid, out}, {1'b1, exp_w});
                end
                k++;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req1 = 1; req2 = 0; in1 = 8'(c * 7); out_ready = 1;
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (c >= 1) begin
                checks++;
                if (gnt1 !== 1'b1) begin
                    failures++;
                    $display("FAIL back_to_back_bubble c=%0d got=%b exp=1", c, gnt1);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req1 = 1; req2 = 0;
            in1 = (c < 2) ? 8'h55 : 8'h66;
            out_ready = !(c >= 2 && c <= 6);
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL backpressure c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({gnt1, gnt2, out_valid, out} !== 11'h155) begin
                    failures++;
                    $display("FAIL backpressure_hold c=%0d got=%h exp=155", c, {gnt1, gnt2, out_valid, out});
                end
            end
            if (c == 7) begin
                checks++;
                if ({gnt1, out} !== 9'h155) begin
                    failures++;
                    $display("FAIL backpressure_release got=%h exp=155", {gnt1, out});
                end
            end
            if (c == 8) begin
                checks++;
                if ({out_valid, out} !== 9'h166) begin
                    failures++;
                    $display("FAIL backpressure_next got=%h exp=166", {out_valid, out});
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req1 = 1; req2 = 1; in1 = 8'h11; in2 = 8'h22; out_ready = 1;
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL midburst c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (c < 6) step();
        end
        // Cycle 6 is beat 2 of requester 2; pull reset between edges.
        #1 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({gnt1, gnt2, select, out_valid, out} !== 12'h000) begin
            failures++;
            $display("FAIL midburst_async got=%h exp=000", {gnt1, gnt2, select, out_valid, out});
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== model_exp()) begin
                failures++;
                $display("FAIL midburst_after c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, model_exp());
            end
            if (c == 1) begin
                checks++;
                if ({gnt1, gnt2} !== 2'b10) begin
                    failures++;
                    $display("FAIL midburst_first got=%b exp=10", {gnt1, gnt2});
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        bit g1p = 0, g2p = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!req1 || g1p) begin
                req1 = ($urandom_range(0, 3) != 0);
                in1  = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req1 = 0;
            end
            if (!req2 || g2p) begin
                req2 = ($urandom_range(0, 3) != 0);
                in2  = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req2 = 0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            e = model_exp();
            g1p = e[11];
            g2p = e[10];
            checks++;
            if ({gnt1, gnt2, select, out_valid, out} !== e) begin
                failures++;
                $display("FAIL random c=%0d got=%h exp=%h", c, {gnt1, gnt2, select, out_valid, out}, e);
            end
            step();
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int c = 0; c < 17; c++) begin
            req1 = 1; req2 = 1; in1 = 8'h11; in2 = 8'h22; out_ready = 1;
            step();
        end
        req1 = 0; req2 = 0;
        #1;
        checks++;
        if ({cnt1, cnt2} !== {16'd8, 16'd8}) begin
            failures++;
            $display("FAIL stats_count got=%0d/%0d exp=8/8", cnt1, cnt2);
        end
        for (int c = 0; c < 65540; c++) begin
            req1 = 1; out_ready = 1;
            @(negedge clk);
        end
        req1 = 0;
        #1;
        checks++;
        if (cnt1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate got=%h exp=ffff", cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_backpressure();
        test_reset_midburst();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
